// File: rtl/threshold_detector_pkg.sv
// -----------------------------------------------------------------------------
// thresh_det_pkg
// Shared types and helpers for the threshold detector.
//   - det_state_e : detector FSM state encoding
//   - det_event_t : one detection event (peak, peak index, width)
//   - to_mag      : two's-complement sample -> offset-binary magnitude domain
//   - sat_inc16 / sat_inc8 : saturating increments
// -----------------------------------------------------------------------------
package thresh_det_pkg;

    localparam int unsigned SAMPLE_W   = 32'd16;
    localparam logic [15:0] MAG_OFFSET = 16'h8000;

    typedef enum logic [1:0] {
        ST_WARMUP  = 2'd0,
        ST_IDLE    = 2'd1,
        ST_DETECT  = 2'd2,
        ST_HOLDOFF = 2'd3
    } det_state_e;

    typedef struct packed {
        logic [15:0] peak;
        logic [15:0] idx;
        logic [15:0] width;
    } det_event_t;

    // Same mapping as the upstream averager: negate, then shift to offset binary.
    function automatic logic [15:0] to_mag(input logic [15:0] d);
        return (~d) + 16'd1 + MAG_OFFSET;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/threshold_detector_if.sv
// -----------------------------------------------------------------------------
// threshold_detector_if
// Event delivery channel (valid/ready) between the detector and its consumer.
//   det_valid : event available        (master -> slave)
//   det_ready : consumer accepts event  (slave -> master)
//   det_peak  : largest cut value in the event
//   det_index : sample index of the peak
//   det_width : hit count, saturating
// -----------------------------------------------------------------------------
interface threshold_detector_if;
    import thresh_det_pkg::*;

    logic                det_valid;
    logic                det_ready;
    logic [SAMPLE_W-1:0] det_peak;
    logic [SAMPLE_W-1:0] det_index;
    logic [SAMPLE_W-1:0] det_width;

    modport master (
        output det_valid, det_peak, det_index, det_width,
        input  det_ready
    );

    modport slave (
        input  det_valid, det_peak, det_index, det_width,
        output det_ready
    );

endinterface

// File: rtl/threshold_detector_sample_delay_line.sv
// -----------------------------------------------------------------------------
// sample_delay_line
// Fixed-depth shift register; dout_o is din_i delayed by DEPTH clocks.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset, clears every stage to 0
//   din_i  : sample in, one per clock
//   dout_o : sample from DEPTH clocks ago
// -----------------------------------------------------------------------------
module sample_delay_line #(
    parameter int unsigned DEPTH = 32'd8,
    parameter int unsigned WIDTH = 32'd16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift one position per clock; stage 0 takes the new sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            stage_q[0] <= din_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/threshold_detector.sv
// -----------------------------------------------------------------------------
// threshold_detector
// Compares the delayed cell-under-test against noise floor + margin and turns
// contiguous runs of hits into events (peak, peak index, width).
// Optional feature macro: THRESH_DET_HYST_EN (exit level = entry level - HYST).
// Ports:
//   clk       : sole clock, rising edge
//   rst       : asynchronous active-low reset
//   D         : two's-complement sample, one per clock
//   threshold : noise floor, offset binary
//   det       : event channel (master side), valid/ready
//   in_det    : registered, high while the FSM is in DETECT
//   drop_cnt  : events lost to a full slot, saturating at 255
// -----------------------------------------------------------------------------
module threshold_detector
    import thresh_det_pkg::*;
#(
    parameter int unsigned N       = 32'd16,
    parameter int unsigned DELAY   = 32'd8,
    parameter int unsigned OFFSET  = 32'd256,
    parameter int unsigned HYST    = 32'd128,
    parameter int unsigned HOLDOFF = 32'd4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] D,
    input  logic [SAMPLE_W-1:0] threshold,
    threshold_detector_if.master det,
    output logic                in_det,
    output logic [7:0]          drop_cnt
);

    localparam logic [15:0] WARM_LAST = 16'(N + DELAY - 32'd1);
    localparam logic [15:0] HOLD_LAST = 16'(HOLDOFF - 32'd1);
    localparam logic [16:0] OFFSET_C  = 17'(OFFSET);
`ifdef THRESH_DET_HYST_EN
    localparam logic [16:0] HYST_C    = 17'(HYST);
`else
    // Hysteresis disabled: the margin collapses to zero, exit == entry.
    localparam logic [16:0] HYST_C    = 17'(HYST) & 17'h0_0000;
`endif

    logic [15:0] mag_s;
    logic [15:0] cut_s;
    logic [15:0] cut_idx_s;
    logic [16:0] entry_sum_s;
    logic [15:0] entry_lvl_s;
    logic [16:0] exit_diff_s;
    logic [15:0] exit_lvl_s;
    logic        hit_entry_s;
    logic        hit_exit_s;
    logic        emit_s;

    det_state_e  state_q, state_d;
    logic [15:0] idx_q;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] peak_q, peak_d;
    logic [15:0] pidx_q, pidx_d;
    logic [15:0] width_q, width_d;
    logic        valid_q, valid_d;
    det_event_t  ev_q, ev_d;
    logic [7:0]  drop_q, drop_d;
    logic        in_det_q;

    assign mag_s = to_mag(D);

    sample_delay_line #(
        .DEPTH (DELAY),
        .WIDTH (SAMPLE_W)
    ) u_cut_dly (
        .clk    (clk),
        .rst_n  (rst),
        .din_i  (mag_s),
        .dout_o (cut_s)
    );

    // The cut was captured DELAY edges ago, when the counter was DELAY lower.
    assign cut_idx_s   = idx_q - 16'(DELAY);
    assign entry_sum_s = {1'b0, threshold} + OFFSET_C;
    assign entry_lvl_s = entry_sum_s[16] ? 16'hFFFF : entry_sum_s[15:0];
    assign exit_diff_s = {1'b0, entry_lvl_s} - HYST_C;
    assign exit_lvl_s  = ({1'b0, entry_lvl_s} >= HYST_C) ? exit_diff_s[15:0] : 16'd0;
    assign hit_entry_s = (cut_s > entry_lvl_s);
    assign hit_exit_s  = (cut_s > exit_lvl_s);

    // Detector FSM: warm-up, run tracking, hold-off.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        peak_d  = peak_q;
        pidx_d  = pidx_q;
        width_d = width_q;
        emit_s  = 1'b0;
        case (state_q)
            ST_WARMUP: begin
                if (cnt_q == WARM_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_IDLE: begin
                if (hit_entry_s) begin
                    state_d = ST_DETECT;
                    peak_d  = cut_s;
                    pidx_d  = cut_idx_s;
                    width_d = 16'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DETECT: begin
                if (hit_exit_s) begin
                    width_d = sat_inc16(width_q);
                    // Strictly greater only: ties keep the earliest peak.
                    if (cut_s > peak_q) begin
                        peak_d = cut_s;
                        pidx_d = cut_idx_s;
                    end else begin
                        peak_d = peak_q;
                    end
                end else begin
                    emit_s = 1'b1;
                    cnt_d  = 16'd0;
                    if (HOLDOFF == 32'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HOLDOFF;
                    end
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_WARMUP;
                cnt_d   = 16'd0;
            end
        endcase
    end

    // Single-entry output slot; a consume on the emit edge frees it in time.
    always_comb begin
        valid_d = valid_q;
        ev_d    = ev_q;
        drop_d  = drop_q;
        if (emit_s) begin
            if (!valid_q || det.det_ready) begin
                valid_d     = 1'b1;
                ev_d.peak   = peak_q;
                ev_d.idx    = pidx_q;
                ev_d.width  = width_q;
            end else begin
                drop_d = sat_inc8(drop_q);
            end
        end else if (valid_q && det.det_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_WARMUP;
            idx_q    <= 16'd0;
            cnt_q    <= 16'd0;
            peak_q   <= 16'd0;
            pidx_q   <= 16'd0;
            width_q  <= 16'd0;
            valid_q  <= 1'b0;
            ev_q     <= '{peak: 16'd0, idx: 16'd0, width: 16'd0};
            drop_q   <= 8'd0;
            in_det_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_q + 16'd1;
            cnt_q    <= cnt_d;
            peak_q   <= peak_d;
            pidx_q   <= pidx_d;
            width_q  <= width_d;
            valid_q  <= valid_d;
            ev_q     <= ev_d;
            drop_q   <= drop_d;
            in_det_q <= (state_d == ST_DETECT);
        end
    end

    assign det.det_valid = valid_q;
    assign det.det_peak  = ev_q.peak;
    assign det.det_index = ev_q.idx;
    assign det.det_width = ev_q.width;
    assign in_det        = in_det_q;
    assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_threshold_detector.sv
// -----------------------------------------------------------------------------
// tb_threshold_detector
// Directed vectors for threshold_detector (default parameters: N=16, DELAY=8,
// OFFSET=256, HYST=128, HOLDOFF=4). Inputs change 1 time unit after the rising
// edge; outputs are read at that point or on the falling edge.
// -----------------------------------------------------------------------------
module tb_threshold_detector;
    import thresh_det_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] D = 16'h0000;
    logic [15:0] threshold = 16'd32768;
    logic        in_det;
    logic [7:0]  drop_cnt;

    threshold_detector_if dif ();

    threshold_detector dut (
        .clk       (clk),
        .rst       (rst),
        .D         (D),
        .threshold (threshold),
        .det       (dif),
        .in_det    (in_det),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         edges = 0;
    det_event_t evq[$];

    // Record every handshake; it completes on the following rising edge.
    always @(negedge clk) begin
        if (rst && dif.det_valid && dif.det_ready) begin
            evq.push_back('{peak: dif.det_peak, idx: dif.det_index, width: dif.det_width});
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input logic [15:0] d);
        D = d;
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(16'h0000);
    endtask

    task automatic check_slot(input string tag, input logic [15:0] pk,
                              input logic [15:0] ix, input logic [15:0] w);
        check_eq({tag, "_valid"}, 32'(dif.det_valid), 32'd1);
        check_eq({tag, "_peak"},  32'(dif.det_peak),  32'(pk));
        check_eq({tag, "_index"}, 32'(dif.det_index), 32'(ix));
        check_eq({tag, "_width"}, 32'(dif.det_width), 32'(w));
    endtask

    task automatic check_ev(input string tag, input int k, input logic [15:0] pk,
                            input logic [15:0] ix, input logic [15:0] w);
        if (evq.size() > k) begin
            check_eq({tag, "_peak"},  32'(evq[k].peak),  32'(pk));
            check_eq({tag, "_index"}, 32'(evq[k].idx),   32'(ix));
            check_eq({tag, "_width"}, 32'(evq[k].width), 32'(w));
        end else begin
            check_eq({tag, "_present"}, 32'(evq.size()), 32'(k + 1));
        end
    endtask

    // Reset release with a strong signal present: silent through 24 edges,
    // DETECT on edge 25, event of samples 16..24 emitted 9 edges later.
    task automatic warm_check(input string tag);
        bit seen;
        int k;
        threshold       = 16'd32768;
        dif.det_ready   = 1'b1;
        rst             = 1'b0;
        D               = 16'hEC78;
        @(posedge clk);
        #1;
        rst   = 1'b1;
        edges = 0;
        seen  = 1'b0;
        for (int i = 0; i < 24; i++) begin
            tick(16'hEC78);
            if (dif.det_valid || in_det) seen = 1'b1;
        end
        check_eq({tag, "_quiet"}, 32'(seen), 32'd0);
        tick(16'hEC78);
        check_eq({tag, "_enter"}, 32'(in_det), 32'd1);
        k = 0;
        do begin
            tick(16'h0000);
            k++;
        end while (!dif.det_valid && k < 30);
        check_eq({tag, "_latency"}, 32'(k), 32'd9);
        check_slot(tag, 16'd37768, 16'd16, 16'd9);
        idle(8);
    endtask

    int s;
    int s2;
    int k;

    initial begin
        dif.det_ready = 1'b1;
        #2;
        check_eq("reset_valid",  32'(dif.det_valid), 32'd0);
        check_eq("reset_in_det", 32'(in_det),        32'd0);
        check_eq("reset_drop",   32'(drop_cnt),      32'd0);
        check_eq("reset_peak",   32'(dif.det_peak),  32'd0);

        warm_check("warm");

        // Single pulse -2000, -3000, -2000 -> peak 35768 at the middle sample.
        idle(10);
        evq.delete();
        s = edges;
        tick(16'hF830);
        tick(16'hF448);
        tick(16'hF830);
        idle(8);
        check_eq("pulse_last_hit_valid",  32'(dif.det_valid), 32'd0);
        check_eq("pulse_last_hit_in_det", 32'(in_det),        32'd1);
        idle(1);
        check_eq("pulse_emit_in_det", 32'(in_det), 32'd0);
        check_slot("pulse", 16'd35768, 16'(s + 1), 16'd3);
        idle(10);

        // Cuts 34000, 32950, 34000 then 32768.
        evq.delete();
        s = edges;
        tick(16'hFB30);
        tick(16'hFF4A);
        tick(16'hFB30);
        idle(20);
        check_eq("hyst_count", 32'(evq.size()), 32'd1);
`ifdef THRESH_DET_HYST_EN
        check_ev("hyst_ev", 0, 16'd34000, 16'(s), 16'd3);
`else
        check_ev("hyst_ev", 0, 16'd34000, 16'(s), 16'd1);
`endif

        // Two isolated hits five samples apart both survive the hold-off.
        evq.delete();
        s = edges;
        tick(16'hFB30);
        idle(5);
        tick(16'hF748);
        idle(20);
        check_eq("gap_count", 32'(evq.size()), 32'd2);
        check_ev("gap_ev0", 0, 16'd34000, 16'(s), 16'd1);
        check_ev("gap_ev1", 1, 16'd35000, 16'(s + 6), 16'd1);

        // Backpressure: A held, B dropped, C loaded on a same-edge consume.
        evq.delete();
        dif.det_ready = 1'b0;
        s = edges;
        tick(16'hFB30);
        idle(5);
        tick(16'hF448);
        idle(12);
        check_slot("bp_hold", 16'd34000, 16'(s), 16'd1);
        check_eq("bp_drop", 32'(drop_cnt), 32'd1);
        s2 = edges;
        tick(16'hF748);
        idle(8);
        check_slot("bp_hold2", 16'd34000, 16'(s), 16'd1);
        dif.det_ready = 1'b1;
        tick(16'h0000);
        check_slot("bp_swap", 16'd35000, 16'(s2), 16'd1);
        check_eq("bp_swap_drop", 32'(drop_cnt), 32'd1);
        idle(3);
        check_eq("bp_count", 32'(evq.size()), 32'd2);
        check_ev("bp_ev0", 0, 16'd34000, 16'(s), 16'd1);
        check_ev("bp_ev1", 1, 16'd35000, 16'(s2), 16'd1);
        idle(6);

        // Entry level clamps at 65535, so a cut of 65535 is not a hit.
        evq.delete();
        threshold = 16'd65400;
        tick(16'h8001);
        idle(8);
        check_eq("clamp_in_det", 32'(in_det), 32'd0);
        idle(8);
        check_eq("clamp_count", 32'(evq.size()), 32'd0);
        check_eq("clamp_valid", 32'(dif.det_valid), 32'd0);

        // Run longer than 65535 hits: width saturates, index wraps correctly.
        threshold = 16'd0;
        s = edges;
        for (int i = 0; i < 65545; i++) tick(16'h0000);
        check_eq("wsat_in_det", 32'(in_det), 32'd1);
        k = 0;
        do begin
            tick(16'h8000);
            k++;
        end while (!dif.det_valid && k < 30);
        check_slot("wsat", 16'd32768, 16'(s - 8), 16'hFFFF);
        threshold = 16'd32768;
        idle(10);

        // Reset in the middle of an event: immediate clear, warm-up again.
        evq.delete();
        for (int i = 0; i < 12; i++) tick(16'hEC78);
        check_eq("arst_pre_in_det", 32'(in_det), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_valid",  32'(dif.det_valid), 32'd0);
        check_eq("arst_in_det", 32'(in_det),        32'd0);
        check_eq("arst_drop",   32'(drop_cnt),      32'd0);
        check_eq("arst_peak",   32'(dif.det_peak),  32'd0);
        check_eq("arst_width",  32'(dif.det_width), 32'd0);
        warm_check("rewarm");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
